// File: rtl/csa_acc_pkg.sv
// Shared definitions for the carry-save accumulator.
//   state_t       : FSM state encoding (2 bits)
//   DEF_*         : default width constants
//   maj3()        : single-bit majority, the carry function of a full adder
package csa_acc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/csa_compress_3to2.sv
// Row of N independent full adders (3:2 compressor), purely combinational.
//   a, b, c : three N-bit addends
//   sum     : bitwise a ^ b ^ c
//   carry   : bitwise majority, NOT shifted; the caller applies the weight shift
module csa_compress_3to2
    import csa_acc_pkg::*;
#(
    parameter int N = DEF_ACC_WIDTH
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    assign sum = a ^ b ^ c;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign carry[i] = maj3(a[i], b[i], c[i]);
    end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator. The running total is held in
// carry-save form (s_reg + c_reg) so each beat costs one 3:2 compression
// with no carry propagation; the final total is resolved bit-serially.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last : operand stream (WIDTH-bit unsigned)
//   out_valid/out_ready            : result handshake
//   out_sum                        : frame total mod 2^ACC_WIDTH
//   out_count                      : beats in frame, saturating
//   out_ovf                        : true total exceeded ACC_WIDTH bits
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for the first beat of a frame
// ACCUM   | compressing further beats into s_reg/c_reg
// RESOLVE | ripple-adding s_reg + c_reg, one bit per cycle, LSB first
// HOLD    | result presented until taken
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    localparam int IDX_W = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ACC_WIDTH - 1);

    state_t                 state;
    state_t                 state_next;
    logic [ACC_WIDTH-1:0]   s_reg;
    logic [ACC_WIDTH-1:0]   c_reg;
    logic [IDX_W-1:0]       bit_idx;
    logic                   ser_carry;
    logic [CNT_WIDTH-1:0]   count;
    logic                   ovf;

    logic [ACC_WIDTH-1:0]   x_ext;
    logic [ACC_WIDTH-1:0]   cmp_sum;
    logic [ACC_WIDTH-1:0]   cmp_maj;
    logic                   beat;
    logic                   take;
    logic                   res_bit;
    logic                   res_carry;
    logic                   res_done;

    assign x_ext    = ACC_WIDTH'(in_data);
    assign in_ready = (state == IDLE) || (state == ACCUM);
    assign beat     = in_valid && in_ready;
    assign take     = out_valid && out_ready;

    csa_compress_3to2 #(.N(ACC_WIDTH)) u_cmp (
        .a     (s_reg),
        .b     (c_reg),
        .c     (x_ext),
        .sum   (cmp_sum),
        .carry (cmp_maj)
    );

    assign res_bit   = s_reg[bit_idx] ^ c_reg[bit_idx] ^ ser_carry;
    assign res_carry = maj3(s_reg[bit_idx], c_reg[bit_idx], ser_carry);
    assign res_done  = (bit_idx == IDX_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat) state_next = in_last ? RESOLVE : ACCUM;
            ACCUM:   if (beat && in_last) state_next = RESOLVE;
            RESOLVE: if (res_done) state_next = HOLD;
            HOLD:    if (take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg     <= '0;
            c_reg     <= '0;
            bit_idx   <= '0;
            ser_carry <= 1'b0;
            count     <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        s_reg     <= x_ext;
                        c_reg     <= '0;
                        count     <= CNT_WIDTH'(1);
                        ovf       <= 1'b0;
                        bit_idx   <= '0;
                        ser_carry <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        s_reg     <= cmp_sum;
                        // Majority carries weigh twice their column; the MSB
                        // carry has no column left and is a lost 2^ACC_WIDTH.
                        c_reg     <= {cmp_maj[ACC_WIDTH-2:0], 1'b0};
                        bit_idx   <= '0;
                        ser_carry <= 1'b0;
                        if (cmp_maj[ACC_WIDTH-1]) ovf <= 1'b1;
                        if (count != '1) count <= count + CNT_WIDTH'(1);
                    end
                end
                RESOLVE: begin
                    out_sum[bit_idx] <= res_bit;
                    ser_carry        <= res_carry;
                    if (res_done) begin
                        bit_idx <= '0;
                        if (res_carry) ovf <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                HOLD: begin
                end
                default: begin
                end
            endcase
            // Registered one cycle behind HOLD entry; drops on the take edge.
            out_valid <= (state == HOLD) && !take;
        end
    end

    assign out_count = count;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator: frames are driven through the
// input handshake, the expected result of each frame is queued when its last
// beat is accepted, and a monitor pops and compares on every output take.
module tb_csa_accumulator;
    import csa_acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_count;
    logic        out_ovf;

    typedef struct {
        logic [15:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fbuf[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         last_stalls;

    always #5 clk = ~clk;

    csa_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e.sum));
                chk("out_count", 32'(out_count), 32'(e.cnt));
                chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    // Sends fbuf as one frame; gap = idle cycles after each accepted beat.
    task automatic send_frame(input bit push_exp, input int gap);
        longint total;
        int     cnt;
        int     stalls;
        bit     ready_s;
        bit     timed_out;
        exp_t   e;
        total = 0;
        cnt = 0;
        stalls = 0;
        timed_out = 0;
        for (int i = 0; i < fbuf.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fbuf[i];
            in_last  = (i == fbuf.size() - 1);
            ready_s  = in_ready;
            @(posedge clk);
            while (!ready_s && !timed_out) begin
                stalls++;
                if (stalls > 200) begin
                    chk("beat_timeout", 32'd1, 32'd0);
                    timed_out = 1;
                end
                @(negedge clk);
                ready_s = in_ready;
                @(posedge clk);
            end
            total += longint'(fbuf[i]);
            if (cnt < 255) cnt++;
            #1;
            if (gap > 0 || i == fbuf.size() - 1) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat (gap) @(posedge clk);
            end
        end
        last_stalls = stalls;
        if (push_exp) begin
            e.sum = total[15:0];
            e.cnt = cnt[7:0];
            e.ovf = (total >= 65536);
            sb.push_back(e);
        end
    endtask

    task automatic wait_valid(input string tag, output int lat);
        bit seen;
        seen = 0;
        lat = 0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) seen = 1;
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;

        // Single-beat frame and latency
        fbuf = '{8'hFF};
        send_frame(1, 0);
        wait_valid("lat_single_timeout", lat);
        chk("latency_single", 32'(lat), 32'd17);
        wait_drain();

        // Beats 1..10 back-to-back
        fbuf.delete();
        for (int i = 1; i <= 10; i++) fbuf.push_back(8'(i));
        send_frame(1, 0);
        chk("ready_b2b_stalls", 32'(last_stalls), 32'd0);
        wait_drain();

        // 258 x 0xFF: wrap, count saturation, overflow
        fbuf.delete();
        for (int i = 0; i < 258; i++) fbuf.push_back(8'hFF);
        send_frame(1, 0);
        wait_drain();

        // Backpressure in HOLD, then an immediate next frame
        out_ready = 1'b0;
        fbuf = '{8'h03, 8'h04};
        send_frame(1, 0);
        wait_valid("hold_timeout", lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_sum", 32'(out_sum), 32'h0007);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("take_valid_low", 32'(out_valid), 32'd0);
        chk("take_in_ready", 32'(in_ready), 32'd1);
        fbuf = '{8'h01};
        send_frame(1, 0);
        chk("b2b_frame_stalls", 32'(last_stalls), 32'd0);
        wait_drain();

        // Reset during the 5th RESOLVE cycle discards the frame
        fbuf = '{8'h80, 8'h80};
        send_frame(0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        repeat (25) @(posedge clk);
        fbuf = '{8'h05};
        send_frame(1, 0);
        wait_drain();

        // Idle gaps between beats
        fbuf = '{8'h10, 8'h20, 8'h30};
        send_frame(1, 3);
        wait_drain();

        // Random frames with mixed gaps
        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(1, 20);
            fbuf.delete();
            for (int i = 0; i < len; i++) fbuf.push_back(8'($urandom_range(0, 255)));
            send_frame(1, f % 2);
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
